// File: rtl/imem_boot_controller_if.sv
// Bus bundle for the instruction-memory boot controller: byte stream from the
// boot source, the core fetch path and the instruction memory port.
// slave is the controller's view; master is the surrounding system's view.
interface imem_boot_controller_if #(
   parameter int ADDR_W = 10
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;

   logic [31:0]       core_pc;
   logic [31:0]       core_instr;
   logic              core_stall;

   logic [ADDR_W-1:0] mem_raddr;
   logic [31:0]       mem_rdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   modport master (
      output byte_valid, byte_data, core_pc, mem_rdata,
      input  byte_ready, core_instr, core_stall,
      input  mem_raddr, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data, core_pc, mem_rdata,
      output byte_ready, core_instr, core_stall,
      output mem_raddr, mem_we, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/imem_boot_controller.sv
// Instruction-memory port owner: streams a little-endian byte image into
// memory while the core is stalled, then hands the read port to the core.
//
// state | meaning
// IDLE  | core stalled, waiting for load_start or go
// HDR0  | receiving low byte of the word count
// HDR1  | receiving high byte of the word count, decides next step
// DATA  | assembling bytes into words and writing them sequentially
// RUN   | core owns the read port, fetches go straight to memory
module imem_boot_controller #(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_boot_controller_if.slave bus,
   input  logic                 load_start,
   input  logic                 go,
   output logic                 load_done,
   output logic                 load_err,
   output logic                 fetch_fault,
   output logic [ADDR_W:0]      words_loaded
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, RUN} state_t;

   state_t          state;
   logic [7:0]      hdr_lo;
   logic [ADDR_W:0] n_words;
   logic [1:0]      lane;
   logic [23:0]     asm_word;
   logic            xfer;
   logic [15:0]     hdr_n;
   logic            pc_bad;

   assign xfer  = bus.byte_valid & bus.byte_ready;
   assign hdr_n = {bus.byte_data, hdr_lo};

   // Sequencer: header parse, byte assembly, sequential writes, port handover.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         bus.mem_we    <= 1'b0;
         bus.mem_waddr <= '0;
         bus.mem_wdata <= '0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         words_loaded  <= '0;
         n_words       <= '0;
         hdr_lo        <= '0;
         lane          <= '0;
         asm_word      <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         load_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state    <= HDR0;
                  load_err <= 1'b0;
               end else if (go) begin
                  state <= RUN;
               end
            end
            HDR0: begin
               if (xfer) begin
                  hdr_lo <= bus.byte_data;
                  state  <= HDR1;
               end
            end
            HDR1: begin
               if (xfer) begin
                  words_loaded <= '0;
                  lane         <= '0;
                  asm_word     <= '0;
                  if (hdr_n == 16'd0) begin
                     state     <= RUN;
                     load_done <= 1'b1;
                  end else if (32'(hdr_n) > DEPTH) begin
                     state    <= IDLE;
                     load_err <= 1'b1;
                  end else begin
                     state   <= DATA;
                     n_words <= (ADDR_W+1)'(hdr_n);
                  end
               end
            end
            DATA: begin
               // The write cycle blocks byte intake, so the end-of-load decision
               // is taken there with the already incremented count.
               if (bus.mem_we) begin
                  if (words_loaded == n_words) begin
                     state     <= RUN;
                     load_done <= 1'b1;
                  end
               end else if (xfer) begin
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_waddr <= words_loaded[ADDR_W-1:0];
                     bus.mem_wdata <= {bus.byte_data, asm_word};
                     words_loaded  <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
                  end else begin
                     // Shifting in from the top leaves byte 0 in [7:0] after three bytes.
                     asm_word <= {bus.byte_data, asm_word[23:8]};
                  end
               end
            end
            RUN: begin
               if (load_start) begin
                  state    <= HDR0;
                  load_err <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pc_bad = (bus.core_pc[1:0] != 2'b00) || (bus.core_pc[31:ADDR_W+2] != '0);

   assign fetch_fault    = (state == RUN) && pc_bad;
   assign bus.core_stall = (state != RUN);
   assign bus.core_instr = (state != RUN) ? 32'd0 : (pc_bad ? NOP_WORD : bus.mem_rdata);
   assign bus.mem_raddr  = (state == RUN) ? bus.core_pc[ADDR_W+1:2] : '0;
   assign bus.byte_ready = (state == HDR0) || (state == HDR1) ||
                           ((state == DATA) && !bus.mem_we);

endmodule

// File: tb/tb_imem_boot_controller.sv
// Bench for imem_boot_controller: random byte images with random valid gaps,
// checked against an image-level reference of memory and expected writes.
module tb_imem_boot_controller;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic              go;
   logic              load_done;
   logic              load_err;
   logic              fetch_fault;
   logic [ADDR_W:0]   words_loaded;

   imem_boot_controller_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_controller #(.ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0013)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .load_start   (load_start),
      .go           (go),
      .load_done    (load_done),
      .load_err     (load_err),
      .fetch_fault  (fetch_fault),
      .words_loaded (words_loaded)
   );

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        init_mem;

   wr_t         exp_q [$];
   logic [7:0]  data_q [$];
   int          n_checks;
   int          n_errors;
   int          done_cnt;
   int          gap_max;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory: async read, sync write; one-shot image copy for preload.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      end else if (bus.mem_we) begin
         mem[bus.mem_waddr] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = mem[bus.mem_raddr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and audit any write or done pulse seen in the new cycle.
   task automatic step();
      wr_t w;
      @(posedge clk);
      #1;
      if (bus.mem_we) begin
         check_val("ready_during_we", bus.byte_ready, 0);
         check_val("we_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_val("we_addr", bus.mem_waddr, w.addr);
            check_val("we_data", bus.mem_wdata, w.data);
         end
      end
      if (load_done) done_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      bit rdy;
      repeat ($urandom_range(0, gap_max)) step();
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         rdy = bus.byte_ready;
         step();
         if (rdy) ok = 1'b1;
      end
      bus.byte_valid = 1'b0;
      check_val("byte_accepted", ok, 1);
   endtask

   // Full load sequence; abort_at >= 0 stops before sending that data byte.
   task automatic do_load(input int n, input bit with_go, input int abort_at);
      logic [15:0] nn;
      logic [7:0]  b;
      logic [31:0] acc;
      wr_t         w;
      nn = 16'(n);
      acc = '0;
      load_start = 1'b1;
      go = with_go;
      step();
      load_start = 1'b0;
      go = 1'b0;
      check_val("hdr0_ready", bus.byte_ready, 1);
      check_val("hdr0_stall", bus.core_stall, 1);
      check_val("hdr0_err_clr", load_err, 0);
      done_cnt = 0;
      send_byte(nn[7:0]);
      send_byte(nn[15:8]);
      if (n == 0) begin
         check_val("n0_done", load_done, 1);
         check_val("n0_stall", bus.core_stall, 0);
         check_val("n0_no_we", bus.mem_we, 0);
         step();
         check_val("n0_done_pulse", load_done, 0);
         check_val("n0_done_cnt", done_cnt, 1);
         return;
      end
      if (n > DEPTH) begin
         check_val("ovf_err", load_err, 1);
         check_val("ovf_stall", bus.core_stall, 1);
         check_val("ovf_idle_ready", bus.byte_ready, 0);
         step();
         check_val("ovf_err_sticky", load_err, 1);
         check_val("ovf_no_done", done_cnt, 0);
         return;
      end
      for (int i = 0; i < 4 * n; i++) begin
         if (i == abort_at) return;
         if (data_q.size() > 0) b = data_q.pop_front();
         else b = 8'($urandom);
         acc[8*(i%4) +: 8] = b;
         if (i % 4 == 3) begin
            w.addr = ADDR_W'(i / 4);
            w.data = acc;
            exp_q.push_back(w);
            ref_mem[i/4] = acc;
         end
         send_byte(b);
      end
      check_val("last_we", bus.mem_we, 1);
      check_val("words_loaded", words_loaded, n);
      check_val("stall_before_done", bus.core_stall, 1);
      step();
      check_val("done_after_we", load_done, 1);
      check_val("stall_falls", bus.core_stall, 0);
      step();
      check_val("done_pulse", load_done, 0);
      check_val("done_cnt", done_cnt, 1);
      check_val("writes_left", exp_q.size(), 0);
   endtask

   task automatic fetch(input logic [31:0] pc);
      bit          fault;
      logic [31:0] exp;
      step();
      bus.core_pc = pc;
      #1;
      fault = (pc % 4 != 0) || (pc >= 4 * DEPTH);
      exp = fault ? 32'h0000_0013 : ref_mem[pc / 4];
      check_val("fetch_instr", bus.core_instr, exp);
      check_val("fetch_fault", fetch_fault, fault);
      check_val("fetch_stall", bus.core_stall, 0);
   endtask

   task automatic random_fetch();
      logic [31:0] pc;
      case ($urandom_range(0, 3))
         0: pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
         1: pc = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         2: pc = $urandom;
         default: pc = 32'($urandom_range(0, 7)) * 4;
      endcase
      fetch(pc);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      done_cnt = 0;
      gap_max  = 0;
      rst = 1'b0;
      load_start = 1'b0;
      go = 1'b0;
      init_mem = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'h00;
      bus.core_pc = 32'h0;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      ref_mem[0] = 32'h0050_0093;
      init_mem = 1'b1;
      step();
      init_mem = 1'b0;
      step();

      check_val("rst_stall", bus.core_stall, 1);
      check_val("rst_ready", bus.byte_ready, 0);
      check_val("rst_we", bus.mem_we, 0);
      check_val("rst_done", load_done, 0);
      check_val("rst_err", load_err, 0);
      check_val("rst_words", words_loaded, 0);
      check_val("rst_instr", bus.core_instr, 0);
      check_val("rst_raddr", bus.mem_raddr, 0);

      rst = 1'b1;
      go = 1'b1;
      step();
      go = 1'b0;
      check_val("boot_stall", bus.core_stall, 0);
      check_val("boot_instr0", bus.core_instr, 32'h0050_0093);
      fetch(32'h4);

      data_q = {8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      do_load(2, 1'b0, -1);
      fetch(32'h0);
      check_val("plan_word0", bus.core_instr, 32'h0050_0093);
      fetch(32'h4);
      check_val("plan_word1", bus.core_instr, 32'h00A0_0113);

      do_load(1025, 1'b0, -1);
      do_load(0, 1'b0, -1);

      do_load(3, 1'b0, 6);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_val("abort_words", words_loaded, 0);
      check_val("abort_stall", bus.core_stall, 1);
      check_val("abort_ready", bus.byte_ready, 0);
      repeat (3) step();
      check_val("abort_no_we", bus.mem_we, 0);
      do_load($urandom_range(1, 4), 1'b1, -1);
      repeat (6) random_fetch();

      for (int k = 0; k < 4; k++) begin
         gap_max = k;
         do_load($urandom_range(1, 6), 1'($urandom_range(0, 1)), -1);
         repeat (8) random_fetch();
      end

      gap_max = 0;
      do_load(DEPTH, 1'b0, -1);
      fetch(32'h0000_0002);
      fetch(32'h0000_1000);
      fetch(32'h0000_0FFC);
      check_val("last_word", bus.core_instr, ref_mem[DEPTH-1]);
      repeat (8) random_fetch();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
- Owns the instruction-memory port and shares it between the core's fetch path and a byte-stream boot loader.
- While loading, the core is stalled and fed zero instructions. Bytes are assembled little-endian into words and written to sequential word addresses.
- After a load completes, the memory read port is handed back to the core.
- Sits between the core's PC/instruction interface, the instruction memory array (async read, sync write), and a UART/debug byte source.

Parameters:
ADDR_W, 10, word-address width of instruction memory (DEPTH = 2**ADDR_W = 1024 words)
NOP_WORD, 32'h00000013, instruction returned on out-of-range or misaligned fetch

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-low reset; sampled on rising clk, rst=0 resets
load_start  input  1  request new program load; honoured in IDLE and RUN, ignored in HDR/DATA
go  input  1  release core from IDLE without loading
byte_valid  input  1  byte source has byte_data valid
byte_data  input  8  stream byte
byte_ready  output  1  controller accepts byte this cycle (transfer = valid & ready)
core_pc  input  32  core fetch byte address
core_instr  output  32  instruction to core
core_stall  output  1  core must hold PC and not commit
mem_raddr  output  ADDR_W  memory read word address
mem_rdata  input  32  memory async read data
mem_we  output  1  memory write enable, one-cycle pulse
mem_waddr  output  ADDR_W  memory write word address
mem_wdata  output  32  memory write data
load_done  output  1  one-cycle pulse when load finishes successfully
load_err  output  1  sticky: header word count exceeded DEPTH
fetch_fault  output  1  combinational: RUN and fetch misaligned/out of range
words_loaded  output  ADDR_W+1  words written in current/last load

Behaviour:
- States: IDLE, HDR0, HDR1, DATA, RUN.
- Reset (rst=0 at clk edge) from any state, including mid-load:
  - state=IDLE; mem_we=0; byte_ready=0; load_done=0; load_err=0; words_loaded=0.
  - Byte assembler and write counter cleared. Memory contents untouched.
- IDLE:
  - core_stall=1; core_instr=0.
  - load_start -> HDR0. go -> RUN. Both set: load_start wins.
- HDR0/HDR1:
  - byte_ready=1; core_stall=1; core_instr=0.
  - Receive the 16-bit word count N, low byte first (HDR0), then high byte (HDR1). On the HDR1 transfer:
    - N=0 -> RUN, load_done pulses in the next cycle.
    - N>DEPTH -> IDLE, load_err set (cleared only by reset or next load_start).
    - Otherwise -> DATA; words_loaded=0.
  - Any load_start clears load_err.
- DATA:
  - byte_ready=1 except in the cycle mem_we is high, when byte_ready=0.
  - Bytes fill lanes [7:0], [15:8], [23:16], [31:24] in order.
  - The transfer completing the 4th byte registers mem_we=1 for exactly the next cycle, with mem_waddr=words_loaded[ADDR_W-1:0] and the assembled word on mem_wdata. words_loaded increments in that same cycle.
  - When words_loaded reaches N after the write: -> RUN, load_done=1 for one cycle (the cycle after the final mem_we).
  - byte_valid gaps just stall the assembler. No timeout.
- RUN:
  - core_stall=0; byte_ready=0; mem_raddr=core_pc[ADDR_W+1:2].
  - If core_pc[1:0]!=0 or core_pc[31:ADDR_W+2]!=0: core_instr=NOP_WORD, fetch_fault=1. Otherwise core_instr=mem_rdata (zero cycles of added latency).
  - load_start -> HDR0; core_stall rises the next cycle.
- mem_raddr outside RUN: driven 0.
- mem_we, mem_waddr, mem_wdata are registered outputs. mem_waddr/mem_wdata hold their last values when mem_we=0.
- Write and read never target the same cycle from different owners: mem_we only occurs in DATA, where the core is stalled.

Test Plan:
- Reset then go with memory preloaded mem[0]=0x00500093, core_pc=0 -> core_stall=0, core_instr=0x00500093 in the same cycle; core_pc=4 returns mem[1].
- load_start, bytes 02 00 | 93 00 50 00 | 13 01 A0 00 -> mem_we pulses at addresses 0 and 1 with 0x00500093 and 0x00A00113; load_done pulses once; words_loaded=2; core_stall falls with load_done.
- Header 01 04 (N=1025) -> load_err=1, state IDLE, core_stall=1; a second load_start clears load_err.
- Header 00 00 -> load_done pulse, RUN, no mem_we.
- Reset asserted after 6 data bytes of a 3-word load -> IDLE, words_loaded=0, no further mem_we; a fresh load writes from address 0.
- RUN with core_pc=0x00000002 and core_pc=0x00001000 -> core_instr=0x00000013, fetch_fault=1; core_pc=0x00000FFC -> mem[1023], fetch_fault=0.
